// File: rtl/andla_fme0_om_writer_pkg.sv
// Shared constants and FSM encoding for the FME0 output-map writer.
package andla_fme0_om_writer_pkg;

  localparam int unsigned FME0_OM_ADDR_INIT_BITWIDTH = 16;
  localparam int unsigned FME0_OM_OW_BITWIDTH        = 16;
  localparam int unsigned FME0_OM_OH_BITWIDTH        = 16;
  localparam int unsigned FME0_OM_OC_BITWIDTH        = 16;
  localparam int unsigned FME0_OM_DATA_BITWIDTH      = 64;
  localparam int unsigned FME0_OM_LANES              = 8;

  typedef enum logic {
    OM_IDLE = 1'b0,
    OM_RUN  = 1'b1
  } om_state_e;

endpackage

// File: rtl/andla_fme0_om_addr_gen.sv
// Output-map address generator: ocg/ow/oh counters with incremental row addressing.
module andla_fme0_om_addr_gen
  import andla_fme0_om_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = FME0_OM_ADDR_INIT_BITWIDTH,
  parameter int unsigned DIM_W  = FME0_OM_OW_BITWIDTH,
  parameter int unsigned LANES  = FME0_OM_LANES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              advance,
  input  logic [DIM_W-1:0]  ow,
  input  logic [DIM_W-1:0]  oh,
  input  logic [DIM_W-1:0]  oc,
  input  logic [ADDR_W-1:0] addr_init,
  input  logic [ADDR_W-1:0] align,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int unsigned   LANE_SH  = (LANES > 1) ? $clog2(LANES) : 0;
  localparam logic [DIM_W:0] LANE_RND = (DIM_W+1)'(LANES - 1);
  localparam logic [DIM_W:0] ONE_C    = (DIM_W+1)'(1);
  localparam logic [DIM_W-1:0] ONE_D  = DIM_W'(1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  logic [DIM_W-1:0]  ow_r, oh_r, ow_idx, oh_idx;
  logic [DIM_W:0]    ocg_r, ocg_idx, ocg_calc;
  logic [ADDR_W-1:0] align_r, row_base, cur_addr;
  logic              ocg_end, ow_end, oh_end;

  assign ocg_calc = ({1'b0, oc} + LANE_RND) >> LANE_SH;
  assign ocg_end  = (ocg_idx == ocg_r - ONE_C);
  assign ow_end   = (ow_idx == ow_r - ONE_D);
  assign oh_end   = (oh_idx == oh_r - ONE_D);
  assign addr     = cur_addr;
  assign last     = ocg_end & ow_end & oh_end;

  // Within a row ow_idx*ocg + ocg_idx is linear, so cur_addr simply counts;
  // only the row boundary needs the pitch added to row_base.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ow_r     <= '0;
      oh_r     <= '0;
      ocg_r    <= '0;
      align_r  <= '0;
      row_base <= '0;
      cur_addr <= '0;
      ocg_idx  <= '0;
      ow_idx   <= '0;
      oh_idx   <= '0;
    end else if (init) begin
      ow_r     <= ow;
      oh_r     <= oh;
      ocg_r    <= ocg_calc;
      align_r  <= align;
      row_base <= addr_init;
      cur_addr <= addr_init;
      ocg_idx  <= '0;
      ow_idx   <= '0;
      oh_idx   <= '0;
    end else if (advance) begin
      if (!ocg_end) begin
        ocg_idx  <= ocg_idx + ONE_C;
        cur_addr <= cur_addr + ONE_A;
      end else begin
        ocg_idx <= '0;
        if (!ow_end) begin
          ow_idx   <= ow_idx + ONE_D;
          cur_addr <= cur_addr + ONE_A;
        end else begin
          ow_idx   <= '0;
          oh_idx   <= oh_end ? '0 : oh_idx + ONE_D;
          row_base <= row_base + align_r;
          cur_addr <= row_base + align_r;
        end
      end
    end
  end

endmodule

// File: rtl/andla_fme0_om_writer.sv
// FME0 output-map write-back: job FSM, beat handshake and registered SRAM write.
module andla_fme0_om_writer
  import andla_fme0_om_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = FME0_OM_ADDR_INIT_BITWIDTH,
  parameter int unsigned DIM_W  = FME0_OM_OW_BITWIDTH,
  parameter int unsigned DATA_W = FME0_OM_DATA_BITWIDTH,
  parameter int unsigned LANES  = FME0_OM_LANES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  rf_fme0_om_ow,
  input  logic [DIM_W-1:0]  rf_fme0_om_oh,
  input  logic [DIM_W-1:0]  rf_fme0_om_oc,
  input  logic [ADDR_W-1:0] rf_fme0_om_addr_init,
  input  logic [ADDR_W-1:0] rf_fme0_om_alignment_ocow,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              om_we,
  output logic [ADDR_W-1:0] om_addr,
  output logic [DATA_W-1:0] om_wdata,
  output logic              busy,
  output logic              done,
  output logic              except_trigger
);

  om_state_e         state, state_next;
  logic              accept, cfg_bad, init, bad, last;
  logic [ADDR_W-1:0] gen_addr;

  assign in_ready = (state == OM_RUN);
  assign busy     = (state == OM_RUN);
  assign accept   = in_valid & in_ready;
  assign init     = (state == OM_IDLE) & start;
  assign cfg_bad  = (rf_fme0_om_ow == '0) | (rf_fme0_om_oh == '0) | (rf_fme0_om_oc == '0);

  always_comb begin
    state_next = state;
    bad        = 1'b0;
    case (state)
      OM_IDLE: begin
        if (start) begin
          if (cfg_bad) bad = 1'b1;
          else         state_next = OM_RUN;
        end
      end
      OM_RUN: begin
        if (abort || (accept && last)) state_next = OM_IDLE;
      end
      default: state_next = OM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= OM_IDLE;
      om_we          <= 1'b0;
      om_addr        <= '0;
      om_wdata       <= '0;
      done           <= 1'b0;
      except_trigger <= 1'b0;
    end else begin
      state          <= state_next;
      om_we          <= accept;
      done           <= accept & last & ~abort;
      except_trigger <= bad;
      if (accept) begin
        om_addr  <= gen_addr;
        om_wdata <= in_data;
      end
    end
  end

  andla_fme0_om_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W),
    .LANES  (LANES)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .advance   (accept),
    .ow        (rf_fme0_om_ow),
    .oh        (rf_fme0_om_oh),
    .oc        (rf_fme0_om_oc),
    .addr_init (rf_fme0_om_addr_init),
    .align     (rf_fme0_om_alignment_ocow),
    .addr      (gen_addr),
    .last      (last)
  );

endmodule

// File: tb/tb_andla_fme0_om_writer.sv
// Randomized self-checking bench for andla_fme0_om_writer against a nested-loop address model.
module tb_andla_fme0_om_writer;

  localparam int LANES = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] ow = '0, oh = '0, oc = '0, ai = '0, al = '0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready, om_we, busy, done, except_trigger;
  logic [15:0] om_addr;
  logic [63:0] om_wdata;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] got_addr[$];

  andla_fme0_om_writer #(
    .ADDR_W (16),
    .DIM_W  (16),
    .DATA_W (64),
    .LANES  (LANES)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .start                     (start),
    .abort                     (abort),
    .rf_fme0_om_ow             (ow),
    .rf_fme0_om_oh             (oh),
    .rf_fme0_om_oc             (oc),
    .rf_fme0_om_addr_init      (ai),
    .rf_fme0_om_alignment_ocow (al),
    .in_valid                  (in_valid),
    .in_data                   (in_data),
    .in_ready                  (in_ready),
    .om_we                     (om_we),
    .om_addr                   (om_addr),
    .om_wdata                  (om_wdata),
    .busy                      (busy),
    .done                      (done),
    .except_trigger            (except_trigger)
  );

  always #5 clk = ~clk;

  // Launches one job and feeds beats; every cycle checks the registered write
  // against the address list produced by plain nested loops.
  task automatic drive_job(input logic [15:0] j_ow, j_oh, j_oc, j_ai, j_al,
                           input int pct, input int abort_beat, input int restart_beat,
                           input int rst_beat, output int n);
    logic [15:0] exp_addr[$];
    int          ocg, total;
    logic [63:0] d;
    logic        acc, ab, rs;
    ocg = (int'(j_oc) + LANES - 1) / LANES;
    for (int y = 0; y < int'(j_oh); y++)
      for (int x = 0; x < int'(j_ow); x++)
        for (int g = 0; g < ocg; g++)
          exp_addr.push_back(16'(longint'(j_ai) + longint'(y) * longint'(j_al)
                                 + longint'(x) * longint'(ocg) + longint'(g)));
    total = exp_addr.size();
    ow = j_ow; oh = j_oh; oc = j_oc; ai = j_ai; al = j_al;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if ({busy, in_ready} !== 2'b11)
      begin miscompares++; $display("FAIL job_launch: busy/in_ready=%b expected 11", {busy, in_ready}); end
    n = 0;
    for (int cyc = 0; cyc < 4000 && n < total; cyc++) begin
      in_valid = ($urandom_range(99) < pct);
      in_data  = {$urandom, $urandom};
      d   = in_data;
      acc = in_valid && in_ready;
      ab  = acc && (n + 1 == abort_beat);
      rs  = acc && (n + 1 == rst_beat);
      abort = ab;
      start = acc && (n + 1 == restart_beat);
      if (rs) rst_n = 1'b0;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
      if (acc) n++;
      vectors++;
      if (om_we !== (acc && !rs))
        begin miscompares++; $display("FAIL we_timing: om_we=%b expected %b (beat %0d)", om_we, acc && !rs, n); end
      if (acc && !rs) begin
        got_addr.push_back(om_addr);
        vectors++;
        if (om_addr !== exp_addr[n-1])
          begin miscompares++; $display("FAIL addr: got %h expected %h (beat %0d)", om_addr, exp_addr[n-1], n); end
        vectors++;
        if (om_wdata !== d)
          begin miscompares++; $display("FAIL wdata: got %h expected %h (beat %0d)", om_wdata, d, n); end
        vectors++;
        if (done !== (n == total && !ab))
          begin miscompares++; $display("FAIL done: got %b expected %b (beat %0d)", done, n == total && !ab, n); end
        if (n == total && !ab) begin
          vectors++;
          if ({busy, in_ready} !== 2'b00)
            begin miscompares++; $display("FAIL end_busy: busy/in_ready=%b expected 00", {busy, in_ready}); end
        end
      end else if (!rs) begin
        vectors++;
        if (done !== 1'b0)
          begin miscompares++; $display("FAIL gap_done: got %b expected 0", done); end
      end
      if (ab || rs) break;
    end
    if (n < total && abort_beat == 0 && rst_beat == 0)
      begin miscompares++; $display("FAIL job_timeout: accepted %0d expected %0d", n, total); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({om_we, busy, in_ready, done, except_trigger} !== 5'b0)
      begin miscompares++; $display("FAIL reset_ctrl: got %b expected 00000", {om_we, busy, in_ready, done, except_trigger}); end
    vectors++;
    if (om_addr !== 16'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0000", om_addr); end
    vectors++;
    if (om_wdata !== 64'h0) begin miscompares++; $display("FAIL reset_wdata: got %h expected 0", om_wdata); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] ref_list[8] = '{16'h100, 16'h101, 16'h102, 16'h103, 16'h110, 16'h111, 16'h112, 16'h113};
    int n;
    got_addr.delete();
    drive_job(16'd2, 16'd2, 16'd12, 16'h100, 16'h10, 100, 0, 0, 0, n);
    vectors++;
    if (got_addr.size() != 8) begin miscompares++; $display("FAIL basic_count: got %0d expected 8", got_addr.size()); end
    for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
      vectors++;
      if (got_addr[i] !== ref_list[i])
        begin miscompares++; $display("FAIL basic_list: got %h expected %h (idx %0d)", got_addr[i], ref_list[i], i); end
    end
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if ({om_we, busy} !== 2'b00) begin miscompares++; $display("FAIL basic_idle: we/busy=%b expected 00", {om_we, busy}); end
    end
  endtask

  task automatic test_gaps();
    int n;
    for (int r = 0; r < 3; r++) begin
      got_addr.delete();
      drive_job(16'd2, 16'd2, 16'd12, 16'h100, 16'h10, 50, 0, 0, 0, n);
      vectors++;
      if (n !== 8) begin miscompares++; $display("FAIL gaps_count: got %0d expected 8", n); end
      @(posedge clk); #1;
    end
    got_addr.delete();
    drive_job(16'd3, 16'd2, 16'd9, 16'h0A0, 16'h20, 60, 0, 0, 0, n);
    @(posedge clk); #1;
  endtask

  task automatic test_bad_config();
    logic [15:0] cfg[3][3] = '{'{16'd2, 16'd2, 16'd0}, '{16'd0, 16'd2, 16'd12}, '{16'd2, 16'd0, 16'd12}};
    for (int k = 0; k < 3; k++) begin
      ow = cfg[k][0]; oh = cfg[k][1]; oc = cfg[k][2]; ai = 16'h100; al = 16'h10;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      vectors++;
      if ({except_trigger, busy, om_we} !== 3'b100)
        begin miscompares++; $display("FAIL bad_cfg_pulse: exc/busy/we=%b expected 100 (case %0d)", {except_trigger, busy, om_we}, k); end
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++;
      if ({except_trigger, busy, om_we} !== 3'b000)
        begin miscompares++; $display("FAIL bad_cfg_after: exc/busy/we=%b expected 000 (case %0d)", {except_trigger, busy, om_we}, k); end
    end
  endtask

  task automatic test_restart_ignored();
    int n;
    got_addr.delete();
    drive_job(16'd2, 16'd2, 16'd12, 16'h100, 16'h10, 100, 0, 3, 0, n);
    vectors++;
    if (got_addr.size() != 8) begin miscompares++; $display("FAIL restart_count: got %0d expected 8", got_addr.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int n;
    got_addr.delete();
    drive_job(16'd2, 16'd2, 16'd12, 16'h100, 16'h10, 100, 0, 0, 0, n);
    // second start lands in the done cycle
    drive_job(16'd1, 16'd2, 16'd8, 16'h200, 16'h8, 100, 0, 0, 0, n);
    vectors++;
    if (got_addr.size() != 10 || got_addr[8] !== 16'h200)
      begin miscompares++; $display("FAIL b2b_first: got %h expected 0200", got_addr.size() > 8 ? got_addr[8] : 16'hxxxx); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    logic [15:0] ref_list[5] = '{16'h100, 16'h101, 16'h102, 16'h103, 16'h110};
    int n;
    got_addr.delete();
    drive_job(16'd2, 16'd2, 16'd12, 16'h100, 16'h10, 70, 5, 0, 0, n);
    vectors++;
    if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL abort_state: busy/done=%b expected 00", {busy, done}); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (i >= got_addr.size() || got_addr[i] !== ref_list[i])
        begin miscompares++; $display("FAIL abort_list: got %h expected %h (idx %0d)", i < got_addr.size() ? got_addr[i] : 16'hxxxx, ref_list[i], i); end
    end
    repeat (2) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      vectors++;
      if ({om_we, done} !== 2'b00) begin miscompares++; $display("FAIL abort_idle: we/done=%b expected 00", {om_we, done}); end
    end
    got_addr.delete();
    drive_job(16'd2, 16'd1, 16'd8, 16'h300, 16'h10, 100, 0, 0, 0, n);
    vectors++;
    if (got_addr.size() == 0 || got_addr[0] !== 16'h300)
      begin miscompares++; $display("FAIL abort_next: got %h expected 0300", got_addr.size() > 0 ? got_addr[0] : 16'hxxxx); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int n;
    got_addr.delete();
    drive_job(16'd2, 16'd2, 16'd12, 16'h100, 16'h10, 100, 0, 0, 3, n);
    vectors++;
    if ({om_we, busy, in_ready, done, except_trigger} !== 5'b0)
      begin miscompares++; $display("FAIL rst_mid_ctrl: got %b expected 00000", {om_we, busy, in_ready, done, except_trigger}); end
    vectors++;
    if ({om_addr, om_wdata} !== 80'h0)
      begin miscompares++; $display("FAIL rst_mid_data: got %h/%h expected 0/0", om_addr, om_wdata); end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (om_we !== 1'b0) begin miscompares++; $display("FAIL rst_mid_idle: om_we=%b expected 0", om_we); end
  endtask

  task automatic test_wrap();
    logic [15:0] ref_list[4] = '{16'hFFFE, 16'hFFFF, 16'h0002, 16'h0003};
    int n;
    got_addr.delete();
    drive_job(16'd1, 16'd2, 16'd16, 16'hFFFE, 16'h0004, 80, 0, 0, 0, n);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= got_addr.size() || got_addr[i] !== ref_list[i])
        begin miscompares++; $display("FAIL wrap_list: got %h expected %h (idx %0d)", i < got_addr.size() ? got_addr[i] : 16'hxxxx, ref_list[i], i); end
    end
    vectors++;
    if (except_trigger !== 1'b0) begin miscompares++; $display("FAIL wrap_exc: got %b expected 0", except_trigger); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_bad_config();
    test_restart_ignored();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
